// File: rtl/tri_wave_seq.sv
// Phase sequencer and DAC output stage for the 1248-entry triangle pROM (tri_pROM).
// Optional macro TRI_SEQ_AMP_EN adds an 'amp' input and one extra amplitude-scaling stage.
module tri_wave_seq #(
   parameter int TBL_LEN = 1248,
   parameter int FRAC_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              sample_tick,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [10:0]       cfg_step_int,
   input  logic [FRAC_W-1:0] cfg_step_frac,
   output logic              cfg_err,
   output logic              rom_ce,
   output logic              rom_oce,
   output logic              rom_reset,
   output logic [10:0]       rom_ad,
   input  logic [7:0]        rom_dout,
`ifdef TRI_SEQ_AMP_EN
   input  logic [7:0]        amp,
`endif
   output logic [7:0]        dac_data,
   output logic              dac_valid
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      RUN_PEND
   } state_e;

   localparam logic [11:0] TBL_LEN_W = 12'(TBL_LEN);

   state_e              state_q;
   logic [10:0]         phase_int_q;
   logic [FRAC_W-1:0]   phase_frac_q;
   logic [10:0]         step_int_q;
   logic [FRAC_W-1:0]   step_frac_q;
   logic [10:0]         shadow_int_q;
   logic [FRAC_W-1:0]   shadow_frac_q;
   logic                rom_ce_q;
   logic [10:0]         rom_ad_q;
   logic                cfg_err_q;
   logic                rd_q;
   logic [7:0]          dac_data_q;
   logic                dac_valid_q;

   logic [FRAC_W:0]     frac_sum_d;
   logic [11:0]         int_sum_d;
   logic                wrap_d;
   logic [10:0]         phase_int_d;
   logic [FRAC_W-1:0]   phase_frac_d;

   logic                cfg_take;
   logic                step_bad;
   logic                cfg_load;
   logic                tick_go;

   // Next phase: the integer part is one bit wider so the frac carry and the wrap compare fit.
   always_comb begin
      frac_sum_d   = {1'b0, phase_frac_q} + {1'b0, step_frac_q};
      int_sum_d    = {1'b0, phase_int_q} + {1'b0, step_int_q} + {11'd0, frac_sum_d[FRAC_W]};
      wrap_d       = (int_sum_d >= TBL_LEN_W);
      phase_int_d  = wrap_d ? 11'(int_sum_d - TBL_LEN_W) : int_sum_d[10:0];
      phase_frac_d = frac_sum_d[FRAC_W-1:0];
   end

   assign cfg_ready = (state_q != RUN_PEND);
   assign cfg_take  = cfg_valid & cfg_ready;
   assign step_bad  = ({1'b0, cfg_step_int} >= TBL_LEN_W);
   assign cfg_load  = cfg_take & ~step_bad;
   assign tick_go   = en & sample_tick & (state_q != IDLE);

   // Sequencer: a rejected step still completes the handshake but leaves the step registers alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         phase_int_q   <= '0;
         phase_frac_q  <= '0;
         step_int_q    <= '0;
         step_frac_q   <= '0;
         shadow_int_q  <= '0;
         shadow_frac_q <= '0;
         rom_ce_q      <= 1'b0;
         rom_ad_q      <= '0;
         cfg_err_q     <= 1'b0;
      end else begin
         cfg_err_q <= cfg_take & step_bad;
         rom_ce_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               phase_int_q  <= '0;
               phase_frac_q <= '0;
               if (cfg_load) begin
                  step_int_q  <= cfg_step_int;
                  step_frac_q <= cfg_step_frac;
               end
               if (en) begin
                  state_q <= RUN;
               end
            end
            RUN, RUN_PEND: begin
               if (!en) begin
                  // Leaving RUN: any pending or just-offered step becomes active at once.
                  state_q      <= IDLE;
                  phase_int_q  <= '0;
                  phase_frac_q <= '0;
                  if (cfg_load) begin
                     step_int_q  <= cfg_step_int;
                     step_frac_q <= cfg_step_frac;
                  end else if (state_q == RUN_PEND) begin
                     step_int_q  <= shadow_int_q;
                     step_frac_q <= shadow_frac_q;
                  end
               end else begin
                  if (tick_go) begin
                     rom_ce_q     <= 1'b1;
                     rom_ad_q     <= phase_int_q;
                     phase_int_q  <= phase_int_d;
                     phase_frac_q <= phase_frac_d;
                     if ((state_q == RUN_PEND) && wrap_d) begin
                        step_int_q  <= shadow_int_q;
                        step_frac_q <= shadow_frac_q;
                        state_q     <= RUN;
                     end
                  end
                  if (cfg_load) begin
                     shadow_int_q  <= cfg_step_int;
                     shadow_frac_q <= cfg_step_frac;
                     state_q       <= RUN_PEND;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef TRI_SEQ_AMP_EN
   logic [15:0] prod_d;
   logic [7:0]  scaled_d;
   logic [7:0]  scaled_q;
   logic        scaled_vld_q;

   // rom_dout * (amp + 1) == rom_dout * amp + rom_dout, which always fits in 16 bits.
   assign prod_d   = ({8'd0, rom_dout} * {8'd0, amp}) + {8'd0, rom_dout};
   assign scaled_d = 8'(prod_d >> 8);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q         <= 1'b0;
         scaled_q     <= '0;
         scaled_vld_q <= 1'b0;
         dac_data_q   <= '0;
         dac_valid_q  <= 1'b0;
      end else begin
         rd_q         <= rom_ce_q;
         scaled_vld_q <= rd_q;
         if (rd_q) begin
            scaled_q <= scaled_d;
         end
         dac_valid_q <= scaled_vld_q;
         if (scaled_vld_q) begin
            dac_data_q <= scaled_q;
         end
      end
   end
`else
   // Output stage runs independently of en so reads already issued always land.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q        <= 1'b0;
         dac_data_q  <= '0;
         dac_valid_q <= 1'b0;
      end else begin
         rd_q        <= rom_ce_q;
         dac_valid_q <= rd_q;
         if (rd_q) begin
            dac_data_q <= rom_dout;
         end
      end
   end
`endif

   assign cfg_err   = cfg_err_q;
   assign rom_ce    = rom_ce_q;
   assign rom_oce   = 1'b1;
   assign rom_reset = reset;
   assign rom_ad    = rom_ad_q;
   assign dac_data  = dac_data_q;
   assign dac_valid = dac_valid_q;

endmodule

// File: tb/tb_tri_wave_seq.sv
// Testbench for tri_wave_seq: directed scenarios plus random traffic against a phase-level model.
// Honours TRI_SEQ_AMP_EN when the design is built with it.
module tb_tri_wave_seq;

   localparam int     TBL_LEN   = 1248;
   localparam int     FRAC_W    = 16;
   localparam longint PHASE_MOD = longint'(TBL_LEN) << FRAC_W;
`ifdef TRI_SEQ_AMP_EN
   localparam int     LAT       = 3;
`else
   localparam int     LAT       = 2;
`endif

   typedef struct {
      int due;
      int addr;
   } sample_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              en;
   logic              sampleTick;
   logic              cfgValid;
   logic              cfgReady;
   logic [10:0]       cfgStepInt;
   logic [FRAC_W-1:0] cfgStepFrac;
   logic              cfgErr;
   logic              romCe;
   logic              romOce;
   logic              romReset;
   logic [10:0]       romAd;
   logic [7:0]        romData;
   logic [7:0]        dacData;
   logic              dacValid;
`ifdef TRI_SEQ_AMP_EN
   logic [7:0]        ampVal;
`endif

   logic [7:0] triTable [TBL_LEN];

   int compareCount;
   int failCount;
   int cycle;

   bit      mRun;
   bit      mPend;
   longint  mPhase;
   longint  mStep;
   longint  mShadow;
   bit      mCe;
   bit      mErr;
   int      mAd;
   bit      mValid;
   logic [7:0] mLastData;
   sample_t pendQ[$];

   tri_wave_seq #(
      .TBL_LEN(TBL_LEN),
      .FRAC_W (FRAC_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .sample_tick  (sampleTick),
      .cfg_valid    (cfgValid),
      .cfg_ready    (cfgReady),
      .cfg_step_int (cfgStepInt),
      .cfg_step_frac(cfgStepFrac),
      .cfg_err      (cfgErr),
      .rom_ce       (romCe),
      .rom_oce      (romOce),
      .rom_reset    (romReset),
      .rom_ad       (romAd),
      .rom_dout     (romData),
`ifdef TRI_SEQ_AMP_EN
      .amp          (ampVal),
`endif
      .dac_data     (dacData),
      .dac_valid    (dacValid)
   );

   always #5 clk = ~clk;

   // Stand-in for tri_pROM: synchronous read, one cycle of latency.
   always @(posedge clk) begin
      if (romReset) begin
         romData <= 8'd0;
      end else if (romCe && romOce) begin
         romData <= triTable[romAd];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cycle, observed, expected);
      end
   endtask

   function automatic logic [7:0] scaleSample(input logic [7:0] d);
`ifdef TRI_SEQ_AMP_EN
      return 8'((int'(d) * (int'(ampVal) + 1)) >> 8);
`else
      return d;
`endif
   endfunction

   // Drives one cycle of inputs, advances the reference model at the edge, then checks every output.
   task automatic applyStimulus(input bit rstIn, input bit enIn, input bit tickIn,
                                input bit cfgValidIn, input int cfgIntIn, input int cfgFracIn);
      longint sum;
      longint newStep;
      bit     wrap;
      bit     accept;
      bit     bad;
      reset       = rstIn;
      en          = enIn;
      sampleTick  = tickIn;
      cfgValid    = cfgValidIn;
      cfgStepInt  = 11'(cfgIntIn);
      cfgStepFrac = FRAC_W'(cfgFracIn);
      @(posedge clk);
      cycle++;
      mValid = 1'b0;
      if (rstIn) begin
         mRun = 0; mPend = 0; mPhase = 0; mStep = 0; mShadow = 0;
         mCe = 0; mErr = 0; mAd = 0; mLastData = 8'd0;
         pendQ.delete();
      end else begin
         accept  = cfgValidIn && !mPend;
         bad     = cfgIntIn >= TBL_LEN;
         newStep = (longint'(cfgIntIn) << FRAC_W) + longint'(cfgFracIn);
         mErr    = accept && bad;
         mCe     = 1'b0;
         if (mRun && enIn && tickIn) begin
            mCe = 1'b1;
            mAd = int'(mPhase >> FRAC_W);
            pendQ.push_back('{cycle + LAT, mAd});
            sum    = mPhase + mStep;
            wrap   = sum >= PHASE_MOD;
            mPhase = wrap ? sum - PHASE_MOD : sum;
            if (mPend && wrap) begin
               mStep = mShadow;
               mPend = 0;
            end
         end
         if (accept && !bad) begin
            if (mRun && enIn) begin
               mShadow = newStep;
               mPend   = 1;
            end else begin
               mStep = newStep;
            end
         end
         if (!enIn) begin
            mPhase = 0;
            if (mPend) begin
               mStep = mShadow;
               mPend = 0;
            end
            mRun = 0;
         end else begin
            mRun = 1;
         end
         if (pendQ.size() > 0 && pendQ[0].due == cycle) begin
            mValid    = 1'b1;
            mLastData = scaleSample(triTable[pendQ[0].addr]);
            void'(pendQ.pop_front());
         end
      end
      #1;
      checkOutput("cfg_ready", cfgReady, !mPend);
      checkOutput("cfg_err", cfgErr, mErr);
      checkOutput("rom_ce", romCe, mCe);
      checkOutput("rom_ad", romAd, mAd);
      checkOutput("rom_oce", romOce, 1);
      checkOutput("rom_reset", romReset, rstIn);
      checkOutput("dac_valid", dacValid, mValid);
      checkOutput("dac_data", dacData, mLastData);
   endtask

   initial begin
      logic [7:0] rampExp [8];
      int         halfExp [6];
      logic [7:0] gotQ[$];
      int         tickCycle;
      int         firstValid;
      int         validCount;
      int         maxAd;
      int         guard;
      bit         enR;
      int         v;
      int         up;

      for (int a = 0; a < TBL_LEN; a++) begin
         up = (a <= TBL_LEN / 2) ? a : TBL_LEN - a;
         v  = (up * 510 + 623) / 1246;
         if (v > 255) v = 255;
         triTable[a] = 8'(v);
      end
      rampExp = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03};
      halfExp = '{0, 0, 1, 1, 2, 2};
      compareCount = 0;
      failCount    = 0;
      cycle        = 0;
`ifdef TRI_SEQ_AMP_EN
      ampVal = 8'hFF;
`endif

      repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("reset_cfg_ready", cfgReady, 1);
      checkOutput("reset_dac_data", dacData, 0);

      // Step 1.0, a tick every cycle.
      applyStimulus(0, 0, 0, 1, 1, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      tickCycle  = cycle + 1;
      firstValid = -1;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, 1, 1, 0, 0, 0);
         if (dacValid) begin
            if (firstValid < 0) firstValid = cycle;
            gotQ.push_back(dacData);
         end
      end
      checkOutput("first_valid_latency", firstValid - tickCycle, LAT);
      checkOutput("ramp_count_ok", gotQ.size() >= 8, 1);
      for (int i = 0; i < 8 && i < gotQ.size(); i++) begin
         checkOutput($sformatf("ramp_%0d", i), gotQ[i], rampExp[i]);
      end

      // Drop en with reads in flight: exactly LAT more pulses, then silence.
      validCount = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 1, 0, 0, 0);
         if (dacValid) validCount++;
      end
      checkOutput("inflight_pulses", validCount, LAT);
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("reenable_ad", romAd, 0);
      checkOutput("reenable_ce", romCe, 1);

      // Step 0.5 loaded while falling back to idle.
      applyStimulus(0, 0, 0, 1, 0, 32'h8000);
      repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 1, 1, 0, 0, 0);
         checkOutput($sformatf("half_ad_%0d", i), romAd, halfExp[i]);
      end

      // Step 1.0, switch to 4.0 at address 100; it takes effect after the wrap.
      applyStimulus(0, 0, 0, 1, 1, 0);
      repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      guard = 0;
      do begin
         applyStimulus(0, 1, 1, 0, 0, 0);
         guard++;
      end while (!(romCe && romAd == 100) && guard < 200);
      checkOutput("reach_ad_100", romAd, 100);
      applyStimulus(0, 1, 1, 1, 4, 0);
      checkOutput("pend_ad_101", romAd, 101);
      checkOutput("pend_ready_low", cfgReady, 0);
      maxAd = 0;
      guard = 0;
      do begin
         applyStimulus(0, 1, 1, 0, 0, 0);
         if (int'(romAd) > maxAd) maxAd = int'(romAd);
         guard++;
      end while (!(romCe && romAd == 11'(TBL_LEN - 1)) && guard < 2000);
      checkOutput("reach_last_ad", romAd, TBL_LEN - 1);
      checkOutput("max_ad_in_range", maxAd <= TBL_LEN - 1, 1);
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("wrap_ad_0", romAd, 0);
      checkOutput("wrap_ready_back", cfgReady, 1);
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("step4_ad_4", romAd, 4);
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("step4_ad_8", romAd, 8);
      applyStimulus(0, 1, 1, 1, TBL_LEN, 0);
      checkOutput("bad_step_err", cfgErr, 1);
      checkOutput("bad_step_ad_12", romAd, 12);
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("bad_step_err_clear", cfgErr, 0);
      checkOutput("bad_step_ad_16", romAd, 16);

`ifdef TRI_SEQ_AMP_EN
      // Amplitude 0x7F at the table peak.
      applyStimulus(0, 0, 0, 1, TBL_LEN / 2, 0);
      repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);
      ampVal = 8'h7F;
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("amp_peak_ad", romAd, 11'h270);
      repeat (LAT) applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("amp_valid", dacValid, 1);
      checkOutput("amp_data", dacData, 8'h7F);
      ampVal = 8'($urandom_range(0, 255));
`endif

      // Random traffic against the model.
      enR = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 59) == 0) enR = ~enR;
         if ($urandom_range(0, 499) == 0) begin
            applyStimulus(1, enR, 0, 0, 0, 0);
         end else if ($urandom_range(0, 19) == 0) begin
            applyStimulus(0, enR, $urandom_range(0, 9) < 6, 1,
                          ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 1300)),
                          int'($urandom_range(0, 65535)));
         end else begin
            applyStimulus(0, enR, $urandom_range(0, 9) < 6, 0, 0, 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
